// File: rtl/result_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : result_scan_pkg                                                 |
// | Brief    : Mode encodings and select-width helper for result_scan_mux.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package result_scan_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    // ceil(log2(n)) for n >= 2
    function automatic int calc_selw(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : scan_counter                                                    |
// | Brief    : Dwell counter plus channel counter with wrap flag.               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module scan_counter #(
    parameter int NCH   = 8,
    parameter int DWELL = 4,
    parameter int SELW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [SELW-1:0] i_load_ch,
    input  logic            i_scan,
    input  logic            i_scan_entry,
    output logic [SELW-1:0] o_ch,
    output logic [SELW-1:0] o_ch_next,
    output logic            o_wrap
);

    localparam int              c_cnt_w    = 16;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DWELL - 1);
    localparam logic [SELW-1:0] c_ch_last  = SELW'(NCH - 1);

    logic [SELW-1:0]    r_ch;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_wrap;

    logic [c_cnt_w-1:0] w_cnt_eff;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic [SELW-1:0]    w_ch_next;
    logic               w_wrap_next;

    always_comb begin
        // A fresh scan entry starts a full dwell regardless of the frozen count
        w_cnt_eff   = i_scan_entry ? '0 : r_cnt;
        w_cnt_next  = r_cnt;
        w_ch_next   = r_ch;
        w_wrap_next = 1'b0;
        if (i_load) begin
            w_ch_next  = i_load_ch;
            w_cnt_next = '0;
        end else if (i_scan) begin
            if (w_cnt_eff == c_cnt_last) begin
                w_cnt_next = '0;
                // Out-of-range channels left by direct mode also land on 0
                if (r_ch >= c_ch_last) begin
                    w_ch_next   = '0;
                    w_wrap_next = 1'b1;
                end else begin
                    w_ch_next = r_ch + 1'b1;
                end
            end else begin
                w_cnt_next = w_cnt_eff + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch   <= '0;
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_ch   <= w_ch_next;
            r_cnt  <= w_cnt_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign o_ch      = r_ch;
    assign o_ch_next = w_ch_next;
    assign o_wrap    = r_wrap;

endmodule
`default_nettype wire

// File: rtl/result_scan_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : result_scan_mux                                                 |
// | Brief    : Registered channel mux with direct, dwell-scan and hold modes.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module result_scan_mux
    import result_scan_pkg::*;
#(
    parameter int NCH   = 8,
    parameter int W     = 7,
    parameter int DWELL = 4,
    parameter int SELW  = calc_selw(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH*W-1:0] din,
    input  logic [SELW-1:0]  sel,
    input  logic [1:0]       mode,
    output logic [W-1:0]     dout,
    output logic [SELW-1:0]  ch,
    output logic             chg,
    output logic             wrap
);

    localparam int c_nslots = 1 << SELW;

    logic [c_nslots*W-1:0] w_din_pad;
    logic                  w_direct;
    logic                  w_scan;
    logic                  w_scan_entry;
    logic [SELW-1:0]       w_idx;
    logic [W-1:0]          w_data;
    logic [SELW-1:0]       w_ch_next;

    logic [W-1:0]          r_dout;
    logic                  r_chg;
    logic                  r_was_scan;

    // Zero-filled slots make every out-of-range index read back as 0
    generate
        if (c_nslots == NCH) begin : g_no_pad
            assign w_din_pad = din;
        end else begin : g_pad
            assign w_din_pad = {{((c_nslots - NCH) * W){1'b0}}, din};
        end
    endgenerate

    assign w_direct     = (mode == MODE_DIRECT);
    assign w_scan       = (mode == MODE_SCAN);
    assign w_scan_entry = w_scan && !r_was_scan;
    assign w_idx        = w_direct ? sel : ch;
    assign w_data       = w_din_pad[int'(w_idx) * W +: W];

    scan_counter #(
        .NCH   (NCH),
        .DWELL (DWELL),
        .SELW  (SELW)
    ) u_scan_counter (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_direct),
        .i_load_ch    (sel),
        .i_scan       (w_scan),
        .i_scan_entry (w_scan_entry),
        .o_ch         (ch),
        .o_ch_next    (w_ch_next),
        .o_wrap       (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout     <= '0;
            r_chg      <= 1'b0;
            r_was_scan <= 1'b0;
        end else begin
            if (w_direct || w_scan) begin
                r_dout <= w_data;
            end
            r_chg      <= (w_ch_next != ch);
            r_was_scan <= w_scan;
        end
    end

    assign dout = r_dout;
    assign chg  = r_chg;

endmodule
`default_nettype wire

// File: tb/tb_result_scan_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_result_scan_mux                                              |
// | Brief    : Self-checking bench for result_scan_mux (three configurations).  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_result_scan_mux;
    import result_scan_pkg::*;

    typedef struct packed {
        logic [6:0] dout;
        logic [3:0] ch;
        logic       chg;
        logic       wrap;
    } exp_t;

    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] sel;
        exp_t       exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // a: NCH=8 DWELL=4, b: NCH=5 DWELL=4, c: NCH=4 DWELL=1
    logic        rst_a, rst_b, rst_c;
    logic [1:0]  mode_a, mode_b, mode_c;
    logic [2:0]  sel_a, sel_b;
    logic [1:0]  sel_c;
    logic [55:0] din_a;
    logic [34:0] din_b;
    logic [27:0] din_c;
    logic [6:0]  dout_a, dout_b, dout_c;
    logic [2:0]  ch_a, ch_b;
    logic [1:0]  ch_c;
    logic        chg_a, chg_b, chg_c, wrap_a, wrap_b, wrap_c;

    logic [6:0]  vals_a [8];
    logic [6:0]  vals_b [5];
    logic [6:0]  vals_c [4];
    vec_t        tbl [12];
    exp_t        sb [$];
    int          passed = 0;
    int          total  = 0;

    result_scan_mux #(.NCH(8), .W(7), .DWELL(4)) u_a (
        .clk(clk), .rst(rst_a), .din(din_a), .sel(sel_a), .mode(mode_a),
        .dout(dout_a), .ch(ch_a), .chg(chg_a), .wrap(wrap_a));
    result_scan_mux #(.NCH(5), .W(7), .DWELL(4)) u_b (
        .clk(clk), .rst(rst_b), .din(din_b), .sel(sel_b), .mode(mode_b),
        .dout(dout_b), .ch(ch_b), .chg(chg_b), .wrap(wrap_b));
    result_scan_mux #(.NCH(4), .W(7), .DWELL(1)) u_c (
        .clk(clk), .rst(rst_c), .din(din_c), .sel(sel_c), .mode(mode_c),
        .dout(dout_c), .ch(ch_c), .chg(chg_c), .wrap(wrap_c));

    function automatic exp_t mk(input logic [6:0] d, input logic [3:0] c,
                                input logic g, input logic w);
        exp_t e;
        e.dout = d;
        e.ch   = c;
        e.chg  = g;
        e.wrap = w;
        return e;
    endfunction

    // Expected outputs of DUT a after the e-th scan edge following reset
    function automatic exp_t scan_a(input int e);
        return mk(vals_a[((e - 1) / 4) % 8], 4'((e / 4) % 8), (e % 4) == 0, (e % 32) == 0);
    endfunction

    task automatic cyc(input int which, input logic r, input logic [1:0] m,
                       input logic [3:0] s, input exp_t e, input string name);
        exp_t a;
        exp_t x;
        case (which)
            0: begin rst_a = r; mode_a = m; sel_a = s[2:0]; end
            1: begin rst_b = r; mode_b = m; sel_b = s[2:0]; end
            default: begin rst_c = r; mode_c = m; sel_c = s[1:0]; end
        endcase
        sb.push_back(e);
        @(posedge clk);
        #1;
        case (which)
            0: begin a.dout = dout_a; a.ch = {1'b0, ch_a}; a.chg = chg_a; a.wrap = wrap_a; end
            1: begin a.dout = dout_b; a.ch = {1'b0, ch_b}; a.chg = chg_b; a.wrap = wrap_b; end
            default: begin a.dout = dout_c; a.ch = {2'b0, ch_c}; a.chg = chg_c; a.wrap = wrap_c; end
        endcase
        x = sb.pop_front();
        total++;
        if (a === x) begin
            passed++;
        end else begin
            $display("FAIL %s: got dout=%h ch=%0d chg=%b wrap=%b, expected dout=%h ch=%0d chg=%b wrap=%b",
                     name, a.dout, a.ch, a.chg, a.wrap, x.dout, x.ch, x.chg, x.wrap);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        mode_a = MODE_HOLD; mode_b = MODE_HOLD; mode_c = MODE_HOLD;
        sel_a = '0; sel_b = '0; sel_c = '0;
        vals_a = '{7'h11, 7'h22, 7'h33, 7'h5A, 7'h44, 7'h55, 7'h66, 7'h77};
        vals_b = '{7'h09, 7'h18, 7'h27, 7'h36, 7'h45};
        vals_c = '{7'h01, 7'h12, 7'h23, 7'h34};
        for (int k = 0; k < 8; k++) din_a[k*7 +: 7] = vals_a[k];
        for (int k = 0; k < 5; k++) din_b[k*7 +: 7] = vals_b[k];
        for (int k = 0; k < 4; k++) din_c[k*7 +: 7] = vals_c[k];

        tbl[0]  = '{MODE_DIRECT, 4'd3, mk(vals_a[3], 4'd3, 1'b1, 1'b0)};
        tbl[1]  = '{MODE_DIRECT, 4'd3, mk(vals_a[3], 4'd3, 1'b0, 1'b0)};
        tbl[2]  = '{MODE_DIRECT, 4'd0, mk(vals_a[0], 4'd0, 1'b1, 1'b0)};
        tbl[3]  = '{MODE_DIRECT, 4'd7, mk(vals_a[7], 4'd7, 1'b1, 1'b0)};
        tbl[4]  = '{MODE_HOLD,   4'd2, mk(vals_a[7], 4'd7, 1'b0, 1'b0)};
        tbl[5]  = '{MODE_RSVD,   4'd5, mk(vals_a[7], 4'd7, 1'b0, 1'b0)};
        tbl[6]  = '{MODE_DIRECT, 4'd5, mk(vals_a[5], 4'd5, 1'b1, 1'b0)};
        tbl[7]  = '{MODE_SCAN,   4'd0, mk(vals_a[5], 4'd5, 1'b0, 1'b0)};
        tbl[8]  = '{MODE_SCAN,   4'd0, mk(vals_a[5], 4'd5, 1'b0, 1'b0)};
        tbl[9]  = '{MODE_SCAN,   4'd0, mk(vals_a[5], 4'd5, 1'b0, 1'b0)};
        tbl[10] = '{MODE_SCAN,   4'd0, mk(vals_a[5], 4'd6, 1'b1, 1'b0)};
        tbl[11] = '{MODE_SCAN,   4'd0, mk(vals_a[6], 4'd6, 1'b0, 1'b0)};

        @(posedge clk);
        #1;

        // Reset, direct/hold/reserved table, scan entry from a direct-selected channel
        cyc(0, 1'b1, MODE_DIRECT, 4'd3, mk(7'd0, 4'd0, 1'b0, 1'b0), "a_reset");
        for (int i = 0; i < 12; i++) begin
            cyc(0, 1'b0, tbl[i].mode, tbl[i].sel, tbl[i].exp, $sformatf("a_tbl%0d", i));
        end

        // Full 32-cycle scan period plus a little beyond the wrap
        cyc(0, 1'b1, MODE_SCAN, 4'd0, mk(7'd0, 4'd0, 1'b0, 1'b0), "a_scan_reset");
        for (int e = 1; e <= 36; e++) begin
            cyc(0, 1'b0, MODE_SCAN, 4'd0, scan_a(e), $sformatf("a_scan_e%0d", e));
        end

        // Hold mid-dwell at ch=2 cnt=2 with live data changing underneath
        cyc(0, 1'b1, MODE_SCAN, 4'd0, mk(7'd0, 4'd0, 1'b0, 1'b0), "a_hold_reset");
        for (int e = 1; e <= 10; e++) begin
            cyc(0, 1'b0, MODE_SCAN, 4'd0, scan_a(e), $sformatf("a_prehold_e%0d", e));
        end
        din_a = ~din_a;
        for (int h = 0; h < 10; h++) begin
            cyc(0, 1'b0, MODE_HOLD, 4'd0, mk(vals_a[2], 4'd2, 1'b0, 1'b0), $sformatf("a_hold%0d", h));
        end
        din_a = ~din_a;
        for (int r = 1; r <= 4; r++) begin
            cyc(0, 1'b0, MODE_SCAN, 4'd0, mk(vals_a[2], 4'(r == 4 ? 3 : 2), r == 4, 1'b0),
                $sformatf("a_resume%0d", r));
        end

        // Reset in the middle of the dwell at ch=5
        cyc(0, 1'b1, MODE_SCAN, 4'd0, mk(7'd0, 4'd0, 1'b0, 1'b0), "a_mid_reset0");
        for (int e = 1; e <= 22; e++) begin
            cyc(0, 1'b0, MODE_SCAN, 4'd0, scan_a(e), $sformatf("a_premid_e%0d", e));
        end
        cyc(0, 1'b1, MODE_SCAN, 4'd0, mk(7'd0, 4'd0, 1'b0, 1'b0), "a_mid_reset");
        for (int e = 1; e <= 8; e++) begin
            cyc(0, 1'b0, MODE_SCAN, 4'd0, scan_a(e), $sformatf("a_postrst_e%0d", e));
        end

        // NCH=5: in-range edge, out-of-range selects, then scan from ch=6
        cyc(1, 1'b1, MODE_DIRECT, 4'd0, mk(7'd0, 4'd0, 1'b0, 1'b0), "b_reset");
        cyc(1, 1'b0, MODE_DIRECT, 4'd4, mk(vals_b[4], 4'd4, 1'b1, 1'b0), "b_sel4");
        cyc(1, 1'b0, MODE_DIRECT, 4'd5, mk(7'd0, 4'd5, 1'b1, 1'b0), "b_sel5");
        cyc(1, 1'b0, MODE_DIRECT, 4'd6, mk(7'd0, 4'd6, 1'b1, 1'b0), "b_sel6");
        for (int e = 1; e <= 3; e++) begin
            cyc(1, 1'b0, MODE_SCAN, 4'd0, mk(7'd0, 4'd6, 1'b0, 1'b0), $sformatf("b_scan_e%0d", e));
        end
        cyc(1, 1'b0, MODE_SCAN, 4'd0, mk(7'd0, 4'd0, 1'b1, 1'b1), "b_scan_wrap");
        cyc(1, 1'b0, MODE_SCAN, 4'd0, mk(vals_b[0], 4'd0, 1'b0, 1'b0), "b_scan_after");

        // DWELL=1: advance every cycle
        cyc(2, 1'b1, MODE_SCAN, 4'd0, mk(7'd0, 4'd0, 1'b0, 1'b0), "c_reset");
        for (int e = 1; e <= 9; e++) begin
            cyc(2, 1'b0, MODE_SCAN, 4'd0, mk(vals_c[(e - 1) % 4], 4'(e % 4), 1'b1, (e % 4) == 0),
                $sformatf("c_scan_e%0d", e));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
